// File: rtl/round_sequencer.sv
// Reflex-trainer round controller: IDLE -> COUNTDOWN -> PLAY -> RESULT, game tick, round timer, scores, respawn.
// Optional: define ROUND_ABORT_EN to let start_pulse abort a round in PLAY back to IDLE.
module round_sequencer #(
    parameter int TICK_DIV      = 100000000,
    parameter int ROUND_SEC     = 30,
    parameter int COUNTDOWN_SEC = 3,
    parameter int TARGET_SEC    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_pulse,
    input  logic       hit_pulse,
    output logic [1:0] state,
    output logic       jump_start,
    output logic [1:0] countdown,
    output logic [4:0] elasped_time,
    output logic [6:0] game_score,
    output logic [6:0] home_score,
    output logic       spawn_req,
    output logic [6:0] miss_count
);

    localparam int CW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        PLAY      = 2'd2,
        RESULT    = 2'd3
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] tick_cnt_reg;
    logic [1:0]    countdown_reg;
    logic [4:0]    elapsed_reg;
    logic [6:0]    game_score_reg;
    logic [6:0]    home_score_reg;
    logic [6:0]    miss_reg;
    logic [2:0]    target_timer_reg;
    logic          spawn_reg;
    logic          jump_reg;

    logic          tick;
    logic          last_tick;
    logic          abort;
    logic [6:0]    score_inc;
    logic [6:0]    miss_inc;

    assign tick      = (tick_cnt_reg == CW'(TICK_DIV - 1));
    assign last_tick = tick && (elapsed_reg == 5'(ROUND_SEC - 1));
    assign score_inc = (game_score_reg >= 7'd99) ? 7'd99 : game_score_reg + 7'd1;
    assign miss_inc  = (miss_reg >= 7'd99) ? 7'd99 : miss_reg + 7'd1;

`ifdef ROUND_ABORT_EN
    assign abort = start_pulse;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            tick_cnt_reg     <= '0;
            countdown_reg    <= '0;
            elapsed_reg      <= '0;
            game_score_reg   <= '0;
            home_score_reg   <= '0;
            miss_reg         <= '0;
            target_timer_reg <= '0;
            spawn_reg        <= 1'b0;
            jump_reg         <= 1'b0;
        end else begin
            spawn_reg <= 1'b0;
            jump_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tick_cnt_reg <= '0;
                    if (start_pulse) begin
                        state_reg     <= COUNTDOWN;
                        countdown_reg <= 2'(COUNTDOWN_SEC);
                    end
                end
                COUNTDOWN: begin
                    if (tick) begin
                        tick_cnt_reg <= '0;
                        if (countdown_reg == 2'd1) begin
                            state_reg        <= PLAY;
                            countdown_reg    <= '0;
                            jump_reg         <= 1'b1;
                            elapsed_reg      <= '0;
                            game_score_reg   <= '0;
                            miss_reg         <= '0;
                            target_timer_reg <= '0;
                        end else begin
                            countdown_reg <= countdown_reg - 2'd1;
                        end
                    end else begin
                        tick_cnt_reg <= tick_cnt_reg + CW'(1);
                    end
                end
                PLAY: begin
                    if (abort) begin
                        state_reg        <= IDLE;
                        tick_cnt_reg     <= '0;
                        elapsed_reg      <= '0;
                        game_score_reg   <= '0;
                        miss_reg         <= '0;
                        target_timer_reg <= '0;
                    end else begin
                        tick_cnt_reg <= tick ? '0 : tick_cnt_reg + CW'(1);
                        if (tick) begin
                            elapsed_reg <= elapsed_reg + 5'd1;
                        end
                        // The closing edge latches the final score, including a hit on that same edge.
                        if (last_tick) begin
                            state_reg      <= RESULT;
                            home_score_reg <= hit_pulse ? score_inc : game_score_reg;
                        end
                        if (hit_pulse) begin
                            game_score_reg   <= score_inc;
                            target_timer_reg <= '0;
                        end else if (tick && !last_tick) begin
                            if (target_timer_reg == 3'(TARGET_SEC - 1)) begin
                                spawn_reg        <= 1'b1;
                                miss_reg         <= miss_inc;
                                target_timer_reg <= '0;
                            end else begin
                                target_timer_reg <= target_timer_reg + 3'd1;
                            end
                        end
                    end
                end
                RESULT: begin
                    tick_cnt_reg <= '0;
                    if (start_pulse) begin
                        state_reg     <= COUNTDOWN;
                        countdown_reg <= 2'(COUNTDOWN_SEC);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign state        = state_reg;
    assign jump_start   = jump_reg;
    assign countdown    = countdown_reg;
    assign elasped_time = elapsed_reg;
    assign game_score   = game_score_reg;
    assign home_score   = home_score_reg;
    assign spawn_req    = spawn_reg;
    assign miss_count   = miss_reg;

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Game-round controller for the reflex trainer; replaces the ad-hoc start/timer/score coupling.
- Sequences IDLE -> COUNTDOWN -> PLAY -> RESULT on right-click pulses.
- Generates the per-second game tick and the round timer, and keeps the live and previous-round scores.
- Schedules target respawn when a target is not hit in time. Sits between the debounced mouse pulses / mouse_on_ball hit detection and ball_gen / display / seven_segment.

Parameters:
- TICK_DIV, 100000000, clk cycles per game second (>=2)
- ROUND_SEC, 30, play duration in seconds (1..31)
- COUNTDOWN_SEC, 3, pre-round countdown in seconds (1..3)
- TARGET_SEC, 2, seconds a target may live before forced respawn (1..7)

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- start_pulse  in  1  one-cycle debounced right-click
- hit_pulse  in  1  one-cycle target hit (new_ball)
- state  out  2  0=IDLE 1=COUNTDOWN 2=PLAY 3=RESULT
- jump_start  out  1  one-cycle pulse, first cycle of PLAY
- countdown  out  2  seconds remaining in COUNTDOWN, else 0
- elasped_time  out  5  whole seconds elapsed in PLAY
- game_score  out  7  hits this round, saturating at 99
- home_score  out  7  final score of last completed round
- spawn_req  out  1  one-cycle forced-respawn request (target missed)
- miss_count  out  7  timeouts this round, saturating at 99

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst). On rst all outputs are 0, state=IDLE, and all internal counters are 0. This applies equally to rst asserted mid-round.
- Tick counter: runs 0..TICK_DIV-1 only in COUNTDOWN and PLAY, held at 0 otherwise. It is cleared on every state change. tick = (counter==TICK_DIV-1). The first tick comes TICK_DIV cycles after state entry.
- IDLE:
  - start_pulse -> COUNTDOWN next edge, countdown=COUNTDOWN_SEC.
  - hit_pulse ignored.
- COUNTDOWN:
  - tick decrements countdown.
  - tick with countdown==1 -> PLAY, countdown=0.
  - start_pulse and hit_pulse ignored.
- Entry to PLAY, same edge:
  - game_score, miss_count, elasped_time and the target timer are cleared.
  - jump_start=1 for exactly the first PLAY cycle.
- PLAY:
  - tick increments elasped_time. The tick that takes it to ROUND_SEC also moves state -> RESULT on that edge.
  - hit_pulse: game_score+1 (held at 99) and target timer cleared.
  - tick without a hit increments the target timer. When it reaches TARGET_SEC: spawn_req=1 for one cycle, miss_count+1 (held at 99), timer cleared.
  - hit_pulse in the same cycle as a timeout: the hit wins. Score+1, no spawn_req, miss_count unchanged, timer cleared.
  - hit_pulse on the final tick is counted.
- Entry to RESULT, same edge: home_score <= final game_score, including any hit counted on that edge.
- RESULT:
  - game_score, miss_count and elasped_time hold.
  - start_pulse -> COUNTDOWN (new round). home_score keeps its value until the next RESULT entry.
- Output timing: spawn_req and jump_start are registered and never asserted outside PLAY. All outputs are registered, no combinational input-to-output paths.
- Widths: the tick counter is $clog2(TICK_DIV) bits. Target timer is 3 bits. Score and miss adds saturate and never wrap.

Optional Feature:
- ROUND_ABORT_EN defined: start_pulse in PLAY aborts to IDLE next edge. game_score, miss_count and elasped_time clear to 0; home_score unchanged; no spawn_req on that edge.
- Not defined: start_pulse in PLAY is ignored.

Test Plan (TICK_DIV=10, ROUND_SEC=5, COUNTDOWN_SEC=3, TARGET_SEC=2 unless stated):
1. Hold rst 3 cycles, release -> state=0, all outputs 0; hit_pulse in IDLE -> game_score stays 0.
2. start_pulse at cycle T:
   - state=1, countdown=3 from T+1.
   - countdown=2 at T+11, 1 at T+21.
   - state=2 at T+31 with jump_start high only at T+31.
   - elasped_time 0->5 over the next 50 cycles; state=3 at T+81.
3. 3 hit_pulses spaced 4 cycles apart early in PLAY, no timeouts -> game_score=3, miss_count=0. At RESULT entry home_score=3. A new start_pulse gives game_score=0 at PLAY entry and home_score still 3.
4. No hits during PLAY -> spawn_req single-cycle pulses at PLAY+20 and PLAY+40, miss_count=2 at RESULT.
5. hit_pulse on the exact cycle of the 2nd-second tick -> game_score+1, spawn_req stays 0, miss_count unchanged.
6. Saturation and reset:
   - ROUND_SEC=31, 120 hit_pulses -> game_score=99, no wrap.
   - Then rst mid-PLAY -> state=0, all outputs 0 including home_score.
   - With ROUND_ABORT_EN, start_pulse mid-PLAY -> IDLE next cycle, game_score=0, home_score unchanged.
